// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, register index, hazard FSM states.
// Also holds the rs/rt field positions of an R/I-type instruction.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    // rs/rt field positions inside an instruction word
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DWAIT   = 2'd1,
        LDSTALL = 2'd2,
        HALTED  = 2'd3
    } fsm_t;

    function automatic regbits_t rsOf(input word_t instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    function automatic regbits_t rtOf(input word_t instr);
        return instr[RT_MSB:RT_LSB];
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of hazard unit signals, shaped like forwarding_unit_if.
// Modport hu is the hazard unit view, dp the datapath view.
interface hazard_unit_if
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic             ihit;
    logic             dhit;
    logic             dmemREN_me;
    logic             dmemWEN_me;
    word_t            instru_de;
    logic             jr_de;
    logic             memRead_ex;
    regbits_t         regDst_ex;
    logic             memRead_me;
    regbits_t         regDst_me;
    logic             brTaken_ex;
    logic             halt_me;
    logic             pcEn;
    logic             en_fd;
    logic             en_de;
    logic             en_em;
    logic             en_mw;
    logic             flush_fd;
    logic             flush_de;
    logic             flush_em;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport hu (
        input  ihit, dhit, dmemREN_me, dmemWEN_me,
        input  instru_de, jr_de,
        input  memRead_ex, regDst_ex,
        input  memRead_me, regDst_me,
        input  brTaken_ex, halt_me,
        output pcEn, en_fd, en_de, en_em, en_mw,
        output flush_fd, flush_de, flush_em,
        output halt, stall_cnt, flush_cnt
    );

    modport dp (
        output ihit, dhit, dmemREN_me, dmemWEN_me,
        output instru_de, jr_de,
        output memRead_ex, regDst_ex,
        output memRead_me, regDst_me,
        output brTaken_ex, halt_me,
        input  pcEn, en_fd, en_de, en_em, en_mw,
        input  flush_fd, flush_de, flush_em,
        input  halt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_perf_cnt.sv
// Free-running stall and flush event counters for the hazard unit.
// Both wrap naturally at 2^CNT_W.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             incStall,
    input  logic             incFlush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    // count stalled cycles
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
        end else if (incStall) begin
            stall_cnt <= stall_cnt + ONE;
        end
    end

    // count taken-branch squashes
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            flush_cnt <= '0;
        end else if (incFlush) begin
            flush_cnt <= flush_cnt + ONE;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline stall/flush control for the five-stage MIPS datapath.
// Handles hazards the forwarding unit cannot bypass.
module hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmemREN_me,
    input  logic             dmemWEN_me,
    input  word_t            instru_de,
    input  logic             jr_de,
    input  logic             memRead_ex,
    input  regbits_t         regDst_ex,
    input  logic             memRead_me,
    input  regbits_t         regDst_me,
    input  logic             brTaken_ex,
    input  logic             halt_me,
    output logic             pcEn,
    output logic             en_fd,
    output logic             en_de,
    output logic             en_em,
    output logic             en_mw,
    output logic             flush_fd,
    output logic             flush_de,
    output logic             flush_em,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    fsm_t     state;
    regbits_t rs;
    regbits_t rt;
    logic     dpend;
    logic     lduse;
    logic     jrhaz;
    logic     useStall;
    logic     brSquash;
    logic     incStall;
    logic     unusedInstr;

    assign rs = rsOf(instru_de);
    assign rt = rtOf(instru_de);
    assign unusedInstr = ^{instru_de[31:26], instru_de[15:0]};

    // hazard conditions from the current stage contents
    always_comb begin
        dpend = (dmemREN_me | dmemWEN_me) & ~dhit;
        lduse = memRead_ex & (regDst_ex != '0)
              & ((regDst_ex == rs) | (regDst_ex == rt));
        jrhaz = jr_de & (rs != '0)
              & ((memRead_ex & (regDst_ex == rs))
               | (memRead_me & (regDst_me == rs) & ~dhit));
        useStall = lduse | jrhaz;
    end

    assign halt = (state == HALTED);

    // stage enables and flushes, highest priority hazard wins
    always_comb begin
        pcEn     = 1'b0;
        en_fd    = 1'b0;
        en_de    = 1'b0;
        en_em    = 1'b0;
        en_mw    = 1'b0;
        flush_fd = 1'b0;
        flush_de = 1'b0;
        flush_em = 1'b0;
        brSquash = 1'b0;
        if (!nRST || state == HALTED) begin
            pcEn = 1'b0;
        end else if (dpend) begin
            pcEn = 1'b0;
        end else if (brTaken_ex) begin
            pcEn     = 1'b1;
            en_fd    = 1'b1;
            en_de    = 1'b1;
            en_em    = 1'b1;
            en_mw    = 1'b1;
            flush_fd = 1'b1;
            flush_de = 1'b1;
            brSquash = 1'b1;
        end else if (useStall) begin
            en_de    = 1'b1;
            en_em    = 1'b1;
            en_mw    = 1'b1;
            flush_de = 1'b1;
        end else if (!ihit) begin
            en_fd    = 1'b1;
            en_de    = 1'b1;
            en_em    = 1'b1;
            en_mw    = 1'b1;
            flush_fd = 1'b1;
        end else begin
            pcEn  = 1'b1;
            en_fd = 1'b1;
            en_de = 1'b1;
            en_em = 1'b1;
            en_mw = 1'b1;
        end
    end

    // state register; HALTED is left only through reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            case (state)
                HALTED: state <= HALTED;
                default: begin
                    if (halt_me && !dpend) begin
                        state <= HALTED;
                    end else if (dpend) begin
                        state <= DWAIT;
                    end else if (brTaken_ex) begin
                        state <= RUN;
                    end else if (useStall) begin
                        state <= LDSTALL;
                    end else begin
                        state <= RUN;
                    end
                end
            endcase
        end
    end

    assign incStall = ~pcEn & (state != HALTED);

    hazard_perf_cnt #(
        .CNT_W(CNT_W)
    ) uPerf (
        .CLK      (CLK),
        .nRST     (nRST),
        .incStall (incStall),
        .incFlush (brSquash),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: combinational vector table
// followed by hand-written multi-cycle sequences.
module tb_hazard_unit;
    import cpu_types_pkg::*;

    localparam int CNT_W = 32;

    typedef struct {
        logic     ihit;
        logic     dhit;
        logic     ren;
        logic     wen;
        regbits_t rs;
        regbits_t rt;
        logic     jr;
        logic     mrEx;
        regbits_t rdEx;
        logic     mrMe;
        regbits_t rdMe;
        logic     br;
        logic [7:0] expOut;
        string    name;
    } vec_t;

    logic             CLK;
    logic             nRST;
    logic             ihit;
    logic             dhit;
    logic             dmemREN_me;
    logic             dmemWEN_me;
    word_t            instru_de;
    logic             jr_de;
    logic             memRead_ex;
    regbits_t         regDst_ex;
    logic             memRead_me;
    regbits_t         regDst_me;
    logic             brTaken_ex;
    logic             halt_me;
    logic             pcEn;
    logic             en_fd;
    logic             en_de;
    logic             en_em;
    logic             en_mw;
    logic             flush_fd;
    logic             flush_de;
    logic             flush_em;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int errors = 0;
    int checks = 0;

    localparam logic [7:0] O_RUN  = 8'hF8;
    localparam logic [7:0] O_LD   = 8'h3A;
    localparam logic [7:0] O_IMIS = 8'h7C;
    localparam logic [7:0] O_BR   = 8'hFE;
    localparam logic [7:0] O_FRZ  = 8'h00;

    vec_t vecs[18];

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .ihit      (ihit),
        .dhit      (dhit),
        .dmemREN_me(dmemREN_me),
        .dmemWEN_me(dmemWEN_me),
        .instru_de (instru_de),
        .jr_de     (jr_de),
        .memRead_ex(memRead_ex),
        .regDst_ex (regDst_ex),
        .memRead_me(memRead_me),
        .regDst_me (regDst_me),
        .brTaken_ex(brTaken_ex),
        .halt_me   (halt_me),
        .pcEn      (pcEn),
        .en_fd     (en_fd),
        .en_de     (en_de),
        .en_em     (en_em),
        .en_mw     (en_mw),
        .flush_fd  (flush_fd),
        .flush_de  (flush_de),
        .flush_em  (flush_em),
        .halt      (halt),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] outs();
        return {pcEn, en_fd, en_de, en_em, en_mw,
                flush_fd, flush_de, flush_em};
    endfunction

    function automatic vec_t mk(
        input string name, input logic ih, input logic dh,
        input logic rn, input logic wn,
        input int rsv, input int rtv, input logic j,
        input logic mx, input int rx,
        input logic mm, input int rm,
        input logic b, input logic [7:0] e);
        vec_t v;
        v.name = name;
        v.ihit = ih;
        v.dhit = dh;
        v.ren = rn;
        v.wen = wn;
        v.rs = regbits_t'(rsv);
        v.rt = regbits_t'(rtv);
        v.jr = j;
        v.mrEx = mx;
        v.rdEx = regbits_t'(rx);
        v.mrMe = mm;
        v.rdMe = regbits_t'(rm);
        v.br = b;
        v.expOut = e;
        return v;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        ihit       = v.ihit;
        dhit       = v.dhit;
        dmemREN_me = v.ren;
        dmemWEN_me = v.wen;
        instru_de  = {6'd0, v.rs, v.rt, 5'd4, 11'h020};
        jr_de      = v.jr;
        memRead_ex = v.mrEx;
        regDst_ex  = v.rdEx;
        memRead_me = v.mrMe;
        regDst_me  = v.rdMe;
        brTaken_ex = v.br;
        halt_me    = 1'b0;
    endtask

    task automatic idle();
        apply(mk("idle", 1, 1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, O_RUN));
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic doReset();
        nRST = 1'b0;
        #1;
        nextCycle();
        nRST = 1'b1;
    endtask

    initial begin
        //          name      ih dh rn wn rs rt jr mx rx mm rm br exp
        vecs[0]  = mk("run",   1, 1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, O_RUN);
        vecs[1]  = mk("ldRs",  1, 1, 0, 0, 3, 1, 0, 1, 3, 0, 0, 0, O_LD);
        vecs[2]  = mk("ldRt",  1, 1, 0, 0, 3, 1, 0, 1, 1, 0, 0, 0, O_LD);
        vecs[3]  = mk("ldZero",1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, O_RUN);
        vecs[4]  = mk("noLd",  1, 1, 0, 0, 3, 1, 0, 0, 3, 0, 0, 0, O_RUN);
        vecs[5]  = mk("imiss", 0, 1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, O_IMIS);
        vecs[6]  = mk("dRd",   1, 0, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0, O_FRZ);
        vecs[7]  = mk("dWr",   1, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0, O_FRZ);
        vecs[8]  = mk("dHit",  1, 1, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0, O_RUN);
        vecs[9]  = mk("br",    1, 1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 1, O_BR);
        vecs[10] = mk("brLd",  1, 1, 0, 0, 3, 1, 0, 1, 3, 0, 0, 1, O_BR);
        vecs[11] = mk("dBr",   1, 0, 1, 0, 1, 2, 0, 0, 0, 0, 0, 1, O_FRZ);
        vecs[12] = mk("jrEx",  1, 1, 0, 0,31, 0, 1, 1,31, 0, 0, 0, O_LD);
        vecs[13] = mk("jrMe",  1, 0, 0, 0,31, 0, 1, 0, 0, 1,31, 0, O_LD);
        vecs[14] = mk("jrMeH", 1, 1, 0, 0,31, 0, 1, 0, 0, 1,31, 0, O_RUN);
        vecs[15] = mk("jrZero",1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, O_RUN);
        vecs[16] = mk("ldImis",0, 1, 0, 0, 3, 1, 0, 1, 3, 0, 0, 0, O_LD);
        vecs[17] = mk("meNoJr",1, 0, 0, 0,31, 0, 0, 0, 0, 1,31, 0, O_RUN);

        nRST = 1'b0;
        idle();
        #2;
        chk("rstOuts", 32'(outs()), 32'(O_FRZ));
        chk("rstHalt", 32'(halt), 32'd0);
        chk("rstStall", stall_cnt, 32'd0);
        chk("rstFlush", flush_cnt, 32'd0);
        nextCycle();
        sample();
        chk("rstHeld", 32'(outs()), 32'(O_FRZ));
        nextCycle();
        nRST = 1'b1;

        for (int i = 0; i < 18; i++) begin
            apply(vecs[i]);
            sample();
            chk({"vec_", vecs[i].name}, 32'(outs()), 32'(vecs[i].expOut));
            chk({"vecHalt_", vecs[i].name}, 32'(halt), 32'd0);
            nextCycle();
        end

        doReset();
        idle();
        sample();
        chk("postRst", 32'(outs()), 32'(O_RUN));
        chk("postRstCnt", stall_cnt, 32'd0);

        // load-use: single bubble
        nextCycle();
        apply(vecs[1]);
        sample();
        chk("luOuts", 32'(outs()), 32'(O_LD));
        nextCycle();
        idle();
        sample();
        chk("luNext", 32'(outs()), 32'(O_RUN));
        chk("luStall", stall_cnt, 32'd1);

        // data wait of three cycles
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            apply(vecs[6]);
            sample();
            chk("dwFrz", 32'(outs()), 32'(O_FRZ));
        end
        nextCycle();
        apply(vecs[8]);
        sample();
        chk("dwRel", 32'(outs()), 32'(O_RUN));
        chk("dwStall", stall_cnt, 32'd4);

        // branch beats load-use
        nextCycle();
        apply(vecs[10]);
        sample();
        chk("brLdOuts", 32'(outs()), 32'(O_BR));
        nextCycle();
        idle();
        sample();
        chk("brLdNext", 32'(outs()), 32'(O_RUN));
        chk("brFlushCnt", flush_cnt, 32'd1);
        chk("brStallCnt", stall_cnt, 32'd4);

        // jr $31 with load of $31 in MEM, dhit low twice
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            apply(mk("jrw", 1, 0, 1, 0, 31, 0, 1, 0, 0, 1, 31, 0, O_FRZ));
            sample();
            chk("jrWait", 32'(outs()), 32'(O_FRZ));
        end
        nextCycle();
        apply(mk("jrh", 1, 1, 1, 0, 31, 0, 1, 0, 0, 1, 31, 0, O_RUN));
        sample();
        chk("jrGo", 32'(outs()), 32'(O_RUN));
        chk("jrStall", stall_cnt, 32'd6);

        // two instruction misses
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            apply(vecs[5]);
            sample();
            chk("imOuts", 32'(outs()), 32'(O_IMIS));
        end
        nextCycle();
        idle();
        sample();
        chk("imStall", stall_cnt, 32'd8);

        // halt is sticky until reset
        nextCycle();
        halt_me = 1'b1;
        sample();
        chk("haltEnter", 32'(outs()), 32'(O_RUN));
        chk("haltNotYet", 32'(halt), 32'd0);
        nextCycle();
        halt_me = 1'b0;
        sample();
        chk("halted", 32'(halt), 32'd1);
        chk("haltOuts", 32'(outs()), 32'(O_FRZ));
        nextCycle();
        apply(vecs[9]);
        sample();
        chk("haltBr", 32'(outs()), 32'(O_FRZ));
        nextCycle();
        idle();
        sample();
        chk("haltSticky", 32'(halt), 32'd1);
        chk("haltStall", stall_cnt, 32'd8);
        chk("haltFlush", flush_cnt, 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk("rstMidHalt", 32'(halt), 32'd0);
        chk("rstMidStall", stall_cnt, 32'd0);
        chk("rstMidFlush", flush_cnt, 32'd0);
        chk("rstMidOuts", 32'(outs()), 32'(O_FRZ));
        nextCycle();
        nRST = 1'b1;
        sample();
        chk("afterHaltRst", 32'(outs()), 32'(O_RUN));
        chk("afterHaltH", 32'(halt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline control counterpart to the forwarding unit in the five-stage MIPS datapath. The forwarding unit resolves data dependencies it can satisfy with bypass values. This block handles everything it cannot: load-use and JR-on-load dependencies, instruction/data memory waits, taken-branch squashes and halt. It drives per-stage latch enables, per-stage flushes and PC enable, keeps a registered state machine, and exposes stall/flush performance counters.

## Interface
- CNT_W, 32: width of the stall and flush performance counters.
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- ihit  in  1  instruction memory returned this cycle.
- dhit  in  1  data memory access completed this cycle.
- dmemREN_me  in  1  memory-stage instruction reads data memory.
- dmemWEN_me  in  1  memory-stage instruction writes data memory.
- instru_de  in  word_t  decode-stage instruction; rs = [25:21], rt = [20:16].
- jr_de  in  1  decode-stage instruction is JR.
- memRead_ex  in  1  execute-stage instruction is a load.
- regDst_ex  in  regbits_t  execute-stage destination register.
- memRead_me  in  1  memory-stage instruction is a load.
- regDst_me  in  regbits_t  memory-stage destination register.
- brTaken_ex  in  1  branch/jump resolved taken in execute.
- halt_me  in  1  HALT is in the memory stage.
- pcEn  out  1  PC register load enable.
- en_fd, en_de, en_em, en_mw  out  1 each  pipeline-register enables.
- flush_fd, flush_de, flush_em  out  1 each  load a bubble (all-zero control) into that register.
- halt  out  1  sticky halted indication.
- stall_cnt  out  CNT_W  cycles with any stage enable deasserted, excluding HALTED.
- flush_cnt  out  CNT_W  number of taken-branch squashes.

## Operation
- States: RUN, DWAIT, LDSTALL, HALTED (fsm_t).
- Conditions:
  - dpend = (dmemREN_me | dmemWEN_me) & ~dhit.
  - lduse = memRead_ex & regDst_ex != 0 & (regDst_ex == rs | regDst_ex == rt).
  - jrhaz = jr_de & ((memRead_ex & regDst_ex == rs) | (memRead_me & regDst_me == rs & ~dhit)), with rs != 0.
- Priority, highest first: HALTED > dpend > brTaken_ex > lduse/jrhaz > ~ihit.
- HALTED:
  - All enables 0, flushes 0, halt = 1.
  - Exits only on reset.
- dpend (freeze):
  - All enables 0, pcEn 0, flushes 0.
  - Next state DWAIT. DWAIT holds until dhit, then returns to RUN and re-evaluates.
- brTaken_ex:
  - All enables 1, pcEn 1, flush_fd = flush_de = 1.
  - flush_cnt increments on the edge.
- lduse / jrhaz:
  - pcEn = en_fd = 0.
  - en_de = en_em = en_mw = 1, flush_de = 1 (bubble into execute).
  - Next state LDSTALL.
  - LDSTALL returns to RUN after one cycle unless the condition is still true.
- ~ihit:
  - pcEn = 0, en_fd = 1 with flush_fd = 1 (bubble into decode).
  - Downstream registers advance.
- RUN, no condition: all enables and pcEn 1, flushes 0.
- halt_me while not dpend: next state HALTED.
- Simultaneous cases:
  - Branch plus load-use: the branch wins, because the dependent instruction is squashed.
  - dpend plus brTaken_ex: freeze. The branch is re-evaluated when the freeze releases.
- Counters:
  - Free-running and wrap at 2^CNT_W.
  - stall_cnt increments whenever pcEn = 0 and state != HALTED.

## Timing
- Reset (nRST low, asynchronous):
  - State RUN, counters 0, halt 0.
  - All enables, pcEn and flushes held 0 for the whole time nRST is low.
- Outputs are combinational from the registered state and current inputs. Zero-cycle response to dhit/ihit.
- State and counters update on the rising CLK edge.
- Load-use inserts exactly one bubble.
- A memory wait lasts exactly as many cycles as dhit is absent.
- A taken branch costs two squashed slots.
- Reset mid-stall discards state; first post-reset cycle is RUN.

## Structure
- fsm_t enum and the rs/rt field offsets go in cpu_types_pkg; word_t/regbits_t are reused from it.
- hazard_unit_if interface with modport hu, mirroring forwarding_unit_if.
- One sub-module, hazard_perf_cnt (the two counters), is natural.

## Test plan
- Load to $3 in EX, add $4,$3,$1 in DE -> one cycle with pcEn = 0, flush_de = 1; RUN next cycle; stall_cnt = 1.
- Load in EX writing $0, dependent reader of $0 -> no stall.
- dmemREN_me with dhit low for 3 cycles -> all enables 0 for 3 cycles; release on the dhit cycle; stall_cnt += 3.
- brTaken_ex with lduse true in the same cycle -> flush_fd = flush_de = 1, no LDSTALL, flush_cnt = 1.
- jr $31 in DE with load of $31 in MEM, dhit low then high -> stall until the dhit cycle, then advance.
- halt_me -> halt = 1 and all enables 0 permanently; nRST pulse mid-HALTED -> RUN, counters 0.
